// File: rtl/seg_pkg.sv
// Shared types, the blank pattern and the active-low BCD to seven-segment decode
// for the multiplexed display driver.
package seg_pkg;

  typedef logic [6:0] segment_t;
  typedef logic [3:0] bcd_t;

  localparam segment_t SEG_BLANK = 7'b1111111;

  // Bit order {a,b,c,d,e,f,g}; a 0 lights the segment. Non-BCD codes blank.
  function automatic segment_t bcd_to_seg(input bcd_t d);
    segment_t s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001101;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational seven-segment decoder for a single BCD nibble.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = bcd_to_seg(bcd);
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed BCD display driver: latches a packed BCD word, scans one digit per
// REFRESH_DIV clocks onto a shared active-low segment bus with leading-zero blanking.
module bcd_display_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_en_L,
  output logic                    invalid
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] value_q;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   en_next;
  logic [3:0]              sel_nibble;
  logic                    sel_blank;
  logic [6:0]              dec_seg;
  logic                    any_bad;
  logic                    zero_run;

  // Refresh divider and digit index
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= bcd_in;
    end
  end

  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Walk from the most significant digit down; a digit is blankable while every
  // nibble from the top down to it is zero. Digit 0 is never blanked.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (value_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      if ((NUM_DIGITS - 1 - k) != 0) begin
        blank_mask[NUM_DIGITS-1-k] = zero_run;
      end
    end
  end

  always_comb begin
    sel_nibble = '0;
    sel_blank  = 1'b0;
    en_next    = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nibble = value_q[4*i +: 4];
        sel_blank  = (BLANK_LEADING != 0) && blank_mask[i];
        en_next[i] = 1'b0;
      end
    end
  end

  bcd_seg_decode u_decode (
    .bcd (sel_nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      segment    <= SEG_BLANK;
      digit_en_L <= '1;
      invalid    <= 1'b0;
    end else begin
      segment    <= sel_blank ? SEG_BLANK : dec_seg;
      digit_en_L <= en_next;
      if (load) invalid <= any_bad;
    end
  end

endmodule
